// File: rtl/pipe_elastic_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_elastic_reg
//  Description : Multi-stage elastic pipeline register. Each stage carries a
//                valid bit. Stages advance whenever the stage ahead of them
//                is empty or advancing, so stalls stop at the first bubble
//                and bubbles collapse toward the output. Flush empties the
//                whole pipe in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_elastic_reg #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 3,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  // ld[k]: stage k may load this cycle; ld[DEPTH] is the downstream sink
  logic [DEPTH:0]   ld;
  // Source of each stage: upstream port for stage 0, previous stage otherwise
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // Ready chain, evaluated from the output end back to the input
  always_comb begin
    ld[DEPTH] = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ld[k] = ~v_q[k] | ld[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_v[k] = in_valid_i;
      assign src_d[k] = in_data_i;
    end else begin : g_body
      assign src_v[k] = v_q[k-1];
      assign src_d[k] = d_q[k-1];
    end
  end

  assign in_ready_o  = ld[0] & ~flush_i;
  assign out_valid_o = v_q[DEPTH-1] & ~flush_i;
  assign out_data_o  = d_q[DEPTH-1];
  assign count_o     = count_q;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  // Stage next-state: loading stages copy their source, payload only moves with a valid entry
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rst_i || flush_i) begin
      v_d = '0;
      if (CLEAR_DATA) begin
        for (int k = 0; k < DEPTH; k++) begin
          d_d[k] = '0;
        end
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) begin
          v_d[k] = src_v[k];
          if (src_v[k]) begin
            d_d[k] = src_d[k];
          end
        end
      end
    end
  end

  // Occupancy counter: +1 on input transfer, -1 on output transfer, net zero on both
  always_comb begin
    count_d = count_q;
    if (rst_i || flush_i) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State registers; reset and flush are folded into the next-state logic
  always_ff @(posedge clk_i) begin
    v_q     <= v_d;
    d_q     <= d_d;
    count_q <= count_d;
  end

endmodule
`default_nettype wire
